// File: rtl/sm_clk_ctrl_pkg.sv
// Shared state encodings, command opcodes and prescaler helper for the CPU clock controller.
// Build option SM_CLK_CTRL_BREAKPOINT_EN enables the address breakpoint in the top level.
package sm_clk_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_HALT  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_STEP  = 2'd2;
   localparam state_t ST_BURST = 2'd3;

   localparam logic [1:0] CMD_HALT  = 2'b00;
   localparam logic [1:0] CMD_RUN   = 2'b01;
   localparam logic [1:0] CMD_STEP  = 2'b10;
   localparam logic [1:0] CMD_BURST = 2'b11;

   // Low-bit mask selecting the prescaler bits that must be zero for a tick.
   function automatic logic [31:0] presc_mask(input logic [31:0] bits);
      return (32'd1 << bits) - 32'd1;
   endfunction

endpackage

// File: rtl/sm_clk_ctrl_presc.sv
// Free-running prescaler: one tick every 2^(SHIFT+divide) clkIn cycles.
// divide is captured only on a tick so a period in progress is never shortened.
module sm_clk_ctrl_presc
   import sm_clk_ctrl_pkg::*;
#(
   parameter int unsigned SHIFT = 16
) (
   input  logic       clkIn,
   input  logic       rst_n,
   input  logic [3:0] divide,
   output logic       tick
);

   logic [31:0] r_cnt;
   logic [3:0]  r_div;
   logic [31:0] w_mask;

   assign w_mask = presc_mask(SHIFT + {28'd0, r_div});
   assign tick   = (r_cnt & w_mask) == 32'd0;

   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 32'd0;
         r_div <= 4'd0;
      end else begin
         r_cnt <= r_cnt + 32'd1;
         if (tick) begin
            r_div <= divide;
         end
      end
   end

endmodule

// File: rtl/sm_clk_ctrl.sv
// CPU clock controller: HALT/RUN/STEP/BURST sequencing of a registered cpuClkEn pulse.
// Define SM_CLK_CTRL_BREAKPOINT_EN to add the bpAddr/bpEnable address breakpoint.
module sm_clk_ctrl
   import sm_clk_ctrl_pkg::*;
#(
   parameter int unsigned SHIFT   = 16,
   parameter int unsigned BURST_W = 16
) (
   input  logic               clkIn,
   input  logic               rst_n,
   input  logic [3:0]         divide,
   input  logic               cmdValid,
   input  logic [1:0]         cmdOp,
   input  logic [BURST_W-1:0] cmdLen,
   output logic               cmdReady,
   input  logic [31:0]        pc,
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
   input  logic [31:0]        bpAddr,
   input  logic               bpEnable,
`endif
   output logic               cpuClkEn,
   output logic               busy,
   output logic               bpHit,
   output logic [31:0]        cycleCount
);

   state_t             r_state, w_state_d;
   logic [BURST_W-1:0] r_rem, w_rem_d;
   logic               r_clk_en, w_pulse;
   logic               r_bp_hit, w_bp_hit_d;
   logic [31:0]        r_cycles;
   logic               w_tick, w_accept, w_bp_match;

   sm_clk_ctrl_presc #(
      .SHIFT (SHIFT)
   ) u_presc (
      .clkIn  (clkIn),
      .rst_n  (rst_n),
      .divide (divide),
      .tick   (w_tick)
   );

   assign cmdReady   = (r_state == ST_HALT) || (r_state == ST_RUN);
   assign w_accept   = cmdValid && cmdReady;
   assign busy       = r_state != ST_HALT;
   assign cpuClkEn   = r_clk_en;
   assign bpHit      = r_bp_hit;
   assign cycleCount = r_cycles;

`ifdef SM_CLK_CTRL_BREAKPOINT_EN
   assign w_bp_match = bpEnable && (pc == bpAddr);
`else
   logic w_unused_pc;
   assign w_bp_match  = 1'b0;
   assign w_unused_pc = ^pc;
`endif

   always_comb begin
      w_state_d  = r_state;
      w_rem_d    = r_rem;
      w_pulse    = 1'b0;
      w_bp_hit_d = r_bp_hit;
      if (w_accept && (cmdOp != CMD_HALT)) begin
         w_bp_hit_d = 1'b0;
      end
      case (r_state)
         ST_HALT: begin
            // No pulse here even on a tick: a freshly accepted command starts at the next tick.
            if (w_accept) begin
               case (cmdOp)
                  CMD_RUN:  w_state_d = ST_RUN;
                  CMD_STEP: w_state_d = ST_STEP;
                  CMD_BURST: begin
                     if (cmdLen != '0) begin
                        w_state_d = ST_BURST;
                        w_rem_d   = cmdLen;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            if (w_accept && (cmdOp == CMD_HALT)) begin
               w_state_d = ST_HALT;
            end else if (w_tick) begin
               if (w_bp_match) begin
                  w_state_d  = ST_HALT;
                  w_bp_hit_d = 1'b1;
               end else begin
                  w_pulse = 1'b1;
               end
            end
         end
         ST_STEP: begin
            // Breakpoint deliberately ignored so a stop at bpAddr can be stepped off.
            if (w_tick) begin
               w_pulse   = 1'b1;
               w_state_d = ST_HALT;
            end
         end
         ST_BURST: begin
            if (w_tick) begin
               if (w_bp_match) begin
                  w_state_d  = ST_HALT;
                  w_rem_d    = '0;
                  w_bp_hit_d = 1'b1;
               end else begin
                  w_pulse = 1'b1;
                  w_rem_d = r_rem - BURST_W'(1);
                  if (r_rem == BURST_W'(1)) begin
                     w_state_d = ST_HALT;
                  end
               end
            end
         end
         default: w_state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_HALT;
         r_rem    <= '0;
         r_clk_en <= 1'b0;
         r_bp_hit <= 1'b0;
         r_cycles <= 32'd0;
      end else begin
         r_state  <= w_state_d;
         r_rem    <= w_rem_d;
         r_clk_en <= w_pulse;
         r_bp_hit <= w_bp_hit_d;
         if (w_pulse) begin
            r_cycles <= r_cycles + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Directed self-checking bench for sm_clk_ctrl with SHIFT=2 (tick every 4 << divide cycles).
// Breakpoint scenario compiled only when SM_CLK_CTRL_BREAKPOINT_EN is defined.
module tb_sm_clk_ctrl;
   import sm_clk_ctrl_pkg::*;

   localparam int unsigned SHIFT   = 2;
   localparam int unsigned BURST_W = 16;

   logic               clkIn    = 1'b0;
   logic               rst_n    = 1'b0;
   logic [3:0]         divide   = 4'd0;
   logic               cmdValid = 1'b0;
   logic [1:0]         cmdOp    = 2'b00;
   logic [BURST_W-1:0] cmdLen   = '0;
   logic [31:0]        pc       = 32'd0;
   logic               cmdReady;
   logic               cpuClkEn;
   logic               busy;
   logic               bpHit;
   logic [31:0]        cycleCount;
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
   logic [31:0]        bpAddr   = 32'd0;
   logic               bpEnable = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   sm_clk_ctrl #(
      .SHIFT   (SHIFT),
      .BURST_W (BURST_W)
   ) dut (
      .clkIn      (clkIn),
      .rst_n      (rst_n),
      .divide     (divide),
      .cmdValid   (cmdValid),
      .cmdOp      (cmdOp),
      .cmdLen     (cmdLen),
      .cmdReady   (cmdReady),
      .pc         (pc),
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
      .bpAddr     (bpAddr),
      .bpEnable   (bpEnable),
`endif
      .cpuClkEn   (cpuClkEn),
      .busy       (busy),
      .bpHit      (bpHit),
      .cycleCount (cycleCount)
   );

   always #5 clkIn = ~clkIn;

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clkIn);
         #1;
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [BURST_W-1:0] len);
      cmdValid = 1'b1;
      cmdOp    = op;
      cmdLen   = len;
      cyc(1);
      cmdValid = 1'b0;
   endtask

   task automatic wait_pulse(input int budget, output int n, output bit got);
      got = 1'b0;
      n   = 0;
      for (int i = 1; i <= budget && !got; i++) begin
         cyc(1);
         if (cpuClkEn === 1'b1) begin
            got = 1'b1;
            n   = i;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (cpuClkEn !== 1'b0 || busy !== 1'b0 || bpHit !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags en=%b busy=%b bp=%b exp=0/0/0", cpuClkEn, busy, bpHit);
      end
      checks++;
      if (cycleCount !== 32'd0) begin
         failures++;
         $display("FAIL reset_count got=%0d exp=0", cycleCount);
      end
      @(negedge clkIn);
      rst_n = 1'b1;
      cyc(1);
      checks++;
      if (cmdReady !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release ready=%b busy=%b exp=1/0", cmdReady, busy);
      end
   endtask

   task automatic test_run();
      int n;
      bit got;
      int pulses;
      issue(CMD_RUN, '0);
      checks++;
      if (busy !== 1'b1 || cmdReady !== 1'b1) begin
         failures++;
         $display("FAIL run_busy busy=%b ready=%b exp=1/1", busy, cmdReady);
      end
      wait_pulse(12, n, got);
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL run_first got=no pulse exp=pulse within 12 cycles");
      end
      for (int k = 2; k <= 5; k++) begin
         wait_pulse(12, n, got);
         checks++;
         if (!got || n != 4) begin
            failures++;
            $display("FAIL run_interval pulse=%0d got=%0b cycles=%0d exp=4", k, got, n);
         end
      end
      issue(CMD_HALT, '0);
      checks++;
      if (cpuClkEn !== 1'b0) begin
         failures++;
         $display("FAIL run_pulse_width en=%b exp=0", cpuClkEn);
      end
      checks++;
      if (busy !== 1'b0 || cycleCount !== 32'd5) begin
         failures++;
         $display("FAIL run_halt busy=%b count=%0d exp=0/5", busy, cycleCount);
      end
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(1);
         if (cpuClkEn === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || cycleCount !== 32'd5) begin
         failures++;
         $display("FAIL run_no_sixth pulses=%0d count=%0d exp=0/5", pulses, cycleCount);
      end
   endtask

   task automatic test_step();
      int n;
      bit got;
      bit ready_bad;
      int extra;
      issue(CMD_STEP, '0);
      checks++;
      if (cmdReady !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL step_accept ready=%b busy=%b exp=0/1", cmdReady, busy);
      end
      got       = 1'b0;
      ready_bad = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         cyc(1);
         if (cpuClkEn === 1'b1) got = 1'b1;
         else if (cmdReady !== 1'b0) ready_bad = 1'b1;
      end
      checks++;
      if (!got || ready_bad) begin
         failures++;
         $display("FAIL step_pulse got=%0b ready_high_early=%0b exp=1/0", got, ready_bad);
      end
      checks++;
      if (cycleCount !== 32'd6 || cmdReady !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL step_done count=%0d ready=%b busy=%b exp=6/1/0",
                  cycleCount, cmdReady, busy);
      end
      // Pulse tick was the previous cycle; next tick is three cycles on.
      extra = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         if (cpuClkEn === 1'b1) extra++;
      end
      issue(CMD_STEP, '0);
      wait_pulse(12, n, got);
      checks++;
      if (!got || n != 4 || extra != 0) begin
         failures++;
         $display("FAIL step_on_tick got=%0b cycles=%0d extra=%0d exp=1/4/0", got, n, extra);
      end
      checks++;
      if (cycleCount !== 32'd7) begin
         failures++;
         $display("FAIL step_count got=%0d exp=7", cycleCount);
      end
   endtask

   task automatic test_burst();
      int n;
      bit got;
      int pulses;
      int busy_cnt;
      divide = 4'd1;
      cyc(8);
      issue(CMD_BURST, 16'd3);
      checks++;
      if (busy !== 1'b1 || cmdReady !== 1'b0) begin
         failures++;
         $display("FAIL burst_accept busy=%b ready=%b exp=1/0", busy, cmdReady);
      end
      wait_pulse(20, n, got);
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL burst_first got=no pulse exp=pulse within 20 cycles");
      end
      for (int k = 2; k <= 3; k++) begin
         wait_pulse(20, n, got);
         checks++;
         if (!got || n != 8) begin
            failures++;
            $display("FAIL burst_interval pulse=%0d got=%0b cycles=%0d exp=8", k, got, n);
         end
      end
      pulses = 0;
      for (int i = 0; i < 24; i++) begin
         cyc(1);
         if (cpuClkEn === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || busy !== 1'b0 || cycleCount !== 32'd10) begin
         failures++;
         $display("FAIL burst_end extra=%0d busy=%b count=%0d exp=0/0/10",
                  pulses, busy, cycleCount);
      end
      issue(CMD_BURST, 16'd0);
      pulses   = 0;
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      for (int i = 0; i < 24; i++) begin
         cyc(1);
         if (cpuClkEn === 1'b1) pulses++;
         if (busy !== 1'b0) busy_cnt++;
      end
      checks++;
      if (pulses != 0 || busy_cnt != 0 || cycleCount !== 32'd10 || cmdReady !== 1'b1) begin
         failures++;
         $display("FAIL burst_zero pulses=%0d busy_cycles=%0d count=%0d ready=%b exp=0/0/10/1",
                  pulses, busy_cnt, cycleCount, cmdReady);
      end
   endtask

`ifdef SM_CLK_CTRL_BREAKPOINT_EN
   task automatic test_breakpoint();
      int n;
      bit got;
      int pulses;
      divide   = 4'd0;
      cyc(16);
      pc       = 32'd0;
      bpAddr   = 32'h10;
      bpEnable = 1'b1;
      issue(CMD_RUN, '0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (cpuClkEn === 1'b1) begin
            pulses++;
            pc = pc + 32'd4;
         end
      end
      checks++;
      if (pulses != 4 || pc !== 32'h10) begin
         failures++;
         $display("FAIL bp_stop pulses=%0d pc=%h exp=4/00000010", pulses, pc);
      end
      checks++;
      if (bpHit !== 1'b1 || busy !== 1'b0 || cycleCount !== 32'd14) begin
         failures++;
         $display("FAIL bp_state hit=%b busy=%b count=%0d exp=1/0/14", bpHit, busy, cycleCount);
      end
      issue(CMD_STEP, '0);
      checks++;
      if (bpHit !== 1'b0) begin
         failures++;
         $display("FAIL bp_clear hit=%b exp=0", bpHit);
      end
      wait_pulse(12, n, got);
      checks++;
      if (!got || cycleCount !== 32'd15) begin
         failures++;
         $display("FAIL bp_step got=%0b count=%0d exp=1/15", got, cycleCount);
      end
      bpEnable = 1'b0;
   endtask
`endif

   task automatic test_reset_mid_burst();
      int n;
      bit got;
      int pulses;
      int busy_cnt;
      issue(CMD_BURST, 16'd4);
      wait_pulse(20, n, got);
      wait_pulse(20, n, got);
      checks++;
      if (!got || cpuClkEn !== 1'b1) begin
         failures++;
         $display("FAIL rst_setup got=%0b en=%b exp=1/1", got, cpuClkEn);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (cpuClkEn !== 1'b0 || busy !== 1'b0 || bpHit !== 1'b0 || cycleCount !== 32'd0) begin
         failures++;
         $display("FAIL rst_async en=%b busy=%b bp=%b count=%0d exp=0/0/0/0",
                  cpuClkEn, busy, bpHit, cycleCount);
      end
      cyc(2);
      @(negedge clkIn);
      rst_n = 1'b1;
      pulses   = 0;
      busy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (cpuClkEn === 1'b1) pulses++;
         if (busy !== 1'b0) busy_cnt++;
      end
      checks++;
      if (pulses != 0 || busy_cnt != 0 || cycleCount !== 32'd0 || cmdReady !== 1'b1) begin
         failures++;
         $display("FAIL rst_quiet pulses=%0d busy_cycles=%0d count=%0d ready=%b exp=0/0/0/1",
                  pulses, busy_cnt, cycleCount, cmdReady);
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_step();
      test_burst();
`ifdef SM_CLK_CTRL_BREAKPOINT_EN
      test_breakpoint();
`endif
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
